// File: rtl/pll_rstseq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_rstseq_pkg;

  typedef enum logic [2:0] {
    PLLRST = 3'd0,
    WAIT   = 3'd1,
    STABLE = 3'd2,
    HOLD   = 3'd3,
    RUN    = 3'd4
  } state_t;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage bit synchronizer for asynchronous status flags; clears to 0 on reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: runs on the PLL reference clock, pulses the PLL reset,
// qualifies lock, then releases a stretched system reset.
// Optional build macro PLL_RSTSEQ_LOSS_COUNT_EN adds a saturating counter of
// RUN->WAIT lock losses on loss_count; without it loss_count is tied to 0.
//
// state  | meaning
// PLLRST | pll_rst held high for PLL_RST_CYCLES
// WAIT   | waiting for synchronized lock, times out into a new PLL reset
// STABLE | lock must stay high for STABLE_CYCLES consecutive cycles
// HOLD   | extra HOLD_CYCLES of sys_rst after lock is deemed stable
// RUN    | sys_rst released, ready high
module pll_reset_sequencer
  import pll_rstseq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 8,
  parameter int LOCK_TIMEOUT   = 1048576,
  parameter int STABLE_CYCLES  = 1024,
  parameter int HOLD_CYCLES    = 16,
  parameter int CNT_W          = 21
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               locked,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic [RETRY_W-1:0] retries,
  output logic [LOSS_W-1:0]  loss_count
);

  // Terminal counts: each state leaves on its last count, so the counter never wraps.
  localparam logic [CNT_W-1:0] PLL_TC     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_TC  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_TC    = CNT_W'(HOLD_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             lock_s;
  logic             retry_inc;

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d     (locked),
    .q     (lock_s)
  );

  // State and shared counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= PLLRST;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic; any state change clears the counter.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + 1'b1;
    retry_inc = 1'b0;
    unique case (state)
      PLLRST: if (cnt == PLL_TC) state_nx = WAIT;
      WAIT: begin
        if (lock_s) begin
          state_nx = STABLE;
        end else if (cnt == TIMEOUT_TC) begin
          state_nx  = PLLRST;
          retry_inc = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s)                state_nx = WAIT;
        else if (cnt == STABLE_TC)  state_nx = HOLD;
      end
      HOLD: begin
        if (!lock_s)              state_nx = WAIT;
        else if (cnt == HOLD_TC)  state_nx = RUN;
      end
      RUN: begin
        cnt_nx = '0;
        if (!lock_s) state_nx = WAIT;
      end
      default: state_nx = PLLRST;
    endcase
    if (state_nx != state) cnt_nx = '0;
  end

  // Registered outputs decoded from the next state so they line up with the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pll_rst <= 1'b1;
      sys_rst <= 1'b1;
      ready   <= 1'b0;
    end else begin
      pll_rst <= (state_nx == PLLRST);
      sys_rst <= (state_nx != RUN);
      ready   <= (state_nx == RUN);
    end
  end

  // Saturating count of lock timeouts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                         retries <= '0;
    else if (retry_inc && retries != '1) retries <= retries + 1'b1;
  end

`ifdef PLL_RSTSEQ_LOSS_COUNT_EN
  logic loss_inc;
  assign loss_inc = (state == RUN) && (state_nx == WAIT);

  // Saturating count of lock losses while running.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                            loss_count <= '0;
    else if (loss_inc && loss_count != '1) loss_count <= loss_count + 1'b1;
  end
`else
  assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: stimulus queues each expected output change with the cycle
// it should happen on; the monitor pops on every observed output change.
module tb_pll_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       locked;
  logic       pll_rst, sys_rst, ready;
  logic [3:0] retries;
  logic [7:0] loss_count;

  pll_reset_sequencer #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .HOLD_CYCLES   (3),
    .CNT_W         (21)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .locked     (locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .retries    (retries),
    .loss_count (loss_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [14:0] snap;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   exp_loss = 0;
  int   exp_ret = 0;

  function automatic logic [14:0] mk(input logic p, input logic s, input logic r,
                                     input int rt, input int ls);
    return {p, s, r, 4'(rt), 8'(ls)};
  endfunction

  function automatic logic [14:0] cur_snap();
    return {pll_rst, sys_rst, ready, retries, loss_count};
  endfunction

  task automatic push(input int c, input logic [14:0] s);
    exp_t e;
    e.cyc  = c;
    e.snap = s;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic check(input string name, input logic [14:0] got, input logic [14:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  task automatic loss_step();
`ifdef PLL_RSTSEQ_LOSS_COUNT_EN
    if (exp_loss < 255) exp_loss++;
`endif
  endtask

  task automatic monitor();
    logic [14:0] prev;
    logic [14:0] cur;
    exp_t        e;
    prev = mk(1'b1, 1'b1, 1'b0, 0, 0);
    forever begin
      @(negedge clock);
      cur = cur_snap();
      if (cur !== prev) begin
        n_vec++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.snap !== cur) begin
            n_bad++;
            $display("FAIL output_change cyc=%0d got=%h want_cyc=%0d want=%h",
                     cyc, cur, e.cyc, e.snap);
          end
        end
        prev = cur;
      end
    end
  endtask

  task automatic stimulus();
    int r, f1, d, d2, w, c;
    reset  = 1'b0;
    locked = 1'b0;
    #1 reset = 1'b1;

    // 1. power-up, no lock: first pulse, one timeout, second pulse
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("reset_state", cur_snap(), mk(1'b1, 1'b1, 1'b0, 0, 0));
    end
    r = cyc;
    push(r + 4,  mk(1'b0, 1'b1, 1'b0, 0, 0));
    push(r + 36, mk(1'b1, 1'b1, 1'b0, 1, 0));
    push(r + 40, mk(1'b0, 1'b1, 1'b0, 1, 0));
    exp_ret = 1;
    reset = 1'b0;
    f1 = r + 40;

    // 2. clean lock: release 14 cycles after locked is driven (2 sync + 12)
    wait_cyc(f1 + 2);
    locked = 1'b1;
    push(cyc + 14, mk(1'b0, 1'b0, 1'b1, exp_ret, exp_loss));

    // 3. loss, relock with a one-cycle glitch at STABLE count 5
    wait_cyc(f1 + 19);
    d = cyc;
    locked = 1'b0;
    loss_step();
    push(d + 3, mk(1'b0, 1'b1, 1'b0, exp_ret, exp_loss));
    wait_cyc(d + 5);
    d2 = cyc;
    locked = 1'b1;
    push(d2 + 21, mk(1'b0, 1'b0, 1'b1, exp_ret, exp_loss));
    wait_cyc(d2 + 6);
    locked = 1'b0;
    wait_cyc(d2 + 7);
    locked = 1'b1;

    // 4. loss in RUN, clean relock
    wait_cyc(d2 + 24);
    d = cyc;
    locked = 1'b0;
    loss_step();
    push(d + 3, mk(1'b0, 1'b1, 1'b0, exp_ret, exp_loss));
    wait_cyc(d + 6);
    locked = 1'b1;
    push(cyc + 14, mk(1'b0, 1'b0, 1'b1, exp_ret, exp_loss));

    // 5. twenty timeouts: retries saturates, every pulse 4 cycles
    wait_cyc(d + 23);
    d = cyc;
    locked = 1'b0;
    loss_step();
    push(d + 3, mk(1'b0, 1'b1, 1'b0, exp_ret, exp_loss));
    w = d + 3;
    for (int i = 0; i < 20; i++) begin
      if (exp_ret < 15) exp_ret++;
      push(w + 32 + 36 * i, mk(1'b1, 1'b1, 1'b0, exp_ret, exp_loss));
      push(w + 36 + 36 * i, mk(1'b0, 1'b1, 1'b0, exp_ret, exp_loss));
    end
    wait_cyc(w + 36 * 20 + 2);
    check("retries_saturated", cur_snap(), mk(1'b0, 1'b1, 1'b0, 15, exp_loss));

    // 6. relock to RUN, then async reset between edges
    locked = 1'b1;
    push(cyc + 14, mk(1'b0, 1'b0, 1'b1, 15, exp_loss));
    wait_cyc(w + 36 * 20 + 20);
    check("run_before_reset", cur_snap(), mk(1'b0, 1'b0, 1'b1, 15, exp_loss));
    c = cyc;
    push(c + 1, mk(1'b1, 1'b1, 1'b0, 0, 0));
    @(posedge clock);
    #2 reset = 1'b1;
    #1 check("async_reset", cur_snap(), mk(1'b1, 1'b1, 1'b0, 0, 0));
    wait_cyc(c + 3);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_expectations got=%0d want=0 next_cyc=%0d", q.size(), q[0].cyc);
    end
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
